// File: rtl/inst_queue.sv
// Decoupling instruction queue between the IF1 FIFO stage and decode.
// Accepts one fetch group per cycle (two slots, or one when in_pc[2]=1),
// stores instructions as individual slots in a circular buffer and presents
// the two oldest slots to decode. Backpressure (in_ready, space_ok,
// nearly_full) is decoded from the registered occupancy count only.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   flush              empties the queue; wins over push and pop
//   in_valid/in_ready  fetch group handshake
//   in_pc..in_excp_flag  fetch group payload
//   space_ok           at least 4 free slots
//   nearly_full        2 or 3 free slots
//   id_pop             slots consumed by decode this cycle (clamped to count)
//   dq_*               two oldest slots; invalid slots read as NOP / zero
module inst_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_next,
    input  logic        in_pc_taken,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_badv,
    input  logic [6:0]  in_exception,
    input  logic [1:0]  in_excp_flag,
    output logic        space_ok,
    output logic        nearly_full,
    input  logic [1:0]  id_pop,
    output logic [1:0]  dq_valid,
    output logic [31:0] dq_pc0,
    output logic [31:0] dq_pc1,
    output logic [31:0] dq_inst0,
    output logic [31:0] dq_inst1,
    output logic [31:0] dq_pc_next0,
    output logic [31:0] dq_pc_next1,
    output logic [1:0]  dq_taken,
    output logic [1:0]  dq_excp_flag,
    output logic [6:0]  dq_exception0,
    output logic [6:0]  dq_exception1,
    output logic [31:0] dq_badv0,
    output logic [31:0] dq_badv1
);

    localparam int unsigned CW       = LOG_DEPTH + 1;
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // Slot storage (intentionally not reset)
    logic [31:0] pc_q      [DEPTH];
    logic [31:0] inst_q    [DEPTH];
    logic [31:0] pc_next_q [DEPTH];
    logic        taken_q   [DEPTH];
    logic        flag_q    [DEPTH];
    logic [6:0]  exc_q     [DEPTH];
    logic [31:0] badv_q    [DEPTH];

    logic [LOG_DEPTH-1:0] head_ptr;
    logic [LOG_DEPTH-1:0] tail_ptr;
    logic [CW-1:0]        count;

    logic                 push;
    logic [CW-1:0]        push_n;
    logic [CW-1:0]        pop_n;
    logic [CW-1:0]        id_pop_w;
    logic [LOG_DEPTH-1:0] tail1;
    logic [LOG_DEPTH-1:0] head1;
    logic [31:0]          pc_plus4;

    // Backpressure from registered count; same-cycle pops are not credited
    assign in_ready    = (count <= CW'(DEPTH - 2));
    assign space_ok    = (count <= CW'(DEPTH - 4));
    assign nearly_full = (count >= CW'(DEPTH - 3)) && (count <= CW'(DEPTH - 2));

    // Push/pop amounts; decode over-pop is clamped to occupancy
    always_comb begin
        push     = in_valid & in_ready;
        push_n   = in_pc[2] ? CW'(1) : CW'(2);
        id_pop_w = CW'(id_pop);
        pop_n    = (id_pop_w > count) ? count : id_pop_w;
        tail1    = tail_ptr + LOG_DEPTH'(1);
        head1    = head_ptr + LOG_DEPTH'(1);
        pc_plus4 = in_pc + 32'd4;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            count    <= count + (push ? push_n : CW'(0)) - pop_n;
            tail_ptr <= tail_ptr + (push ? LOG_DEPTH'(push_n) : LOG_DEPTH'(0));
            head_ptr <= head_ptr + LOG_DEPTH'(pop_n);
        end
    end

    // Slot writes; only the last slot of a group carries the prediction
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_q[tail_ptr]      <= in_pc;
            inst_q[tail_ptr]    <= in_inst0;
            pc_next_q[tail_ptr] <= in_pc[2] ? in_pc_next : pc_plus4;
            taken_q[tail_ptr]   <= in_pc[2] & in_pc_taken;
            flag_q[tail_ptr]    <= in_excp_flag[0];
            exc_q[tail_ptr]     <= in_exception;
            badv_q[tail_ptr]    <= in_badv;
            if (!in_pc[2]) begin
                pc_q[tail1]      <= pc_plus4;
                inst_q[tail1]    <= in_inst1;
                pc_next_q[tail1] <= in_pc_next;
                taken_q[tail1]   <= in_pc_taken;
                flag_q[tail1]    <= in_excp_flag[1];
                exc_q[tail1]     <= in_exception;
                badv_q[tail1]    <= in_badv;
            end
        end
    end

    // Dequeue view of the two oldest slots
    always_comb begin
        dq_valid[0] = (count >= CW'(1));
        dq_valid[1] = (count >= CW'(2));

        dq_pc0          = dq_valid[0] ? pc_q[head_ptr]      : 32'd0;
        dq_inst0        = dq_valid[0] ? inst_q[head_ptr]    : INST_NOP;
        dq_pc_next0     = dq_valid[0] ? pc_next_q[head_ptr] : 32'd0;
        dq_taken[0]     = dq_valid[0] & taken_q[head_ptr];
        dq_excp_flag[0] = dq_valid[0] & flag_q[head_ptr];
        dq_exception0   = dq_valid[0] ? exc_q[head_ptr]     : 7'd0;
        dq_badv0        = dq_valid[0] ? badv_q[head_ptr]    : 32'd0;

        dq_pc1          = dq_valid[1] ? pc_q[head1]      : 32'd0;
        dq_inst1        = dq_valid[1] ? inst_q[head1]    : INST_NOP;
        dq_pc_next1     = dq_valid[1] ? pc_next_q[head1] : 32'd0;
        dq_taken[1]     = dq_valid[1] & taken_q[head1];
        dq_excp_flag[1] = dq_valid[1] & flag_q[head1];
        dq_exception1   = dq_valid[1] ? exc_q[head1]     : 7'd0;
        dq_badv1        = dq_valid[1] ? badv_q[head1]    : 32'd0;
    end

endmodule
